mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV64 pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM outputs: ALU result as the address, rs2 data as store data, control bits.
- Performs byte-addressed little-endian loads and stores with a configurable wait-state FSM, and resolves branches into pc_src.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
- MEM_BYTES, 256, data memory size in bytes; power of two; address index = alu_result_in[log2(MEM_BYTES)-1:0] (upper bits ignored, wraps).
- WAIT_CYCLES, 0, extra wait cycles per memory access; an access occupies WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- adder_in  in  64  branch target from EX/MEM.
- zero_in  in  1  ALU zero flag from EX/MEM.
- alu_result_in  in  64  address or ALU result.
- write_data_in  in  64  store data (rs2).
- rd_in  in  5  destination register.
- funct3_in  in  3  access size/sign.
- MemtoReg_in, RegWrite_in, branch_in, MemRead_in, MemWrite_in  in  1 each  control.
- pc_src  out  1  take branch (combinational).
- branch_target  out  64  equals adder_in (combinational).
- stall  out  1  freeze IF/ID/EX and the EX/MEM register (combinational).
- read_data_out  out  64  MEM/WB: extended load data.
- alu_result_out  out  64  MEM/WB: alu_result_in.
- rd_out  out  5  MEM/WB.
- MemtoReg_out, RegWrite_out  out  1 each  MEM/WB.
- misaligned_out  out  1  MEM/WB: misaligned access flag.

Behaviour:
- Reset (reset=0, async): FSM to IDLE, counter=0, all MEM/WB outputs 0. Memory array is not cleared; an in-flight access is abandoned and its write discarded. Combinational outputs still follow their inputs; stall=0 while in reset.
- Access request: req = (MemRead_in | MemWrite_in) & ~misaligned.
- Both MemRead_in and MemWrite_in set: store is performed and read_data_out=0.
- Sizes (funct3_in):
  - 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd: load sign-extended.
  - 100 lbu, 101 lhu, 110 lwu: zero-extended.
  - 111: treated as ld/sd.
  - Stores use funct3_in[1:0] for size.
- Misaligned: address not a multiple of the access size; byte accesses are never misaligned.
  - No memory read/write, no stall.
  - Next MEM/WB: misaligned_out=1, RegWrite_out=0.
- Byte addressing: little-endian. Byte k of the access is at (addr+k) mod MEM_BYTES.
- FSM IDLE:
  - No req: stall=0.
  - req with WAIT_CYCLES=0: stall=0; the access completes at this posedge.
  - req with WAIT_CYCLES>0: stall=1; go to BUSY with count=WAIT_CYCLES.
- FSM BUSY: count decrements each cycle. stall=1 while count!=1. When count==1: stall=0, the access completes at this posedge, FSM returns to IDLE.
- Stall contract: inputs are held stable by upstream while stall=1.
- Completion posedge: store bytes written; MEM/WB loads read data and the control fields.
- While stall=1: MEM/WB loads a bubble (RegWrite_out=0, MemtoReg_out=0, rd_out=0, misaligned_out=0).
- Non-memory instructions: MEM/WB loads every cycle with read_data_out=0.
- Read data: reflects memory contents before any same-edge write. Back-to-back store then load to the same address returns the stored value, because the store commits at the earlier edge.
- pc_src = branch_in & zero_in & ~stall.
- Latency: 1 cycle from inputs to MEM/WB outputs with WAIT_CYCLES=0; otherwise WAIT_CYCLES+1 cycles.

Test Plan:
- WAIT_CYCLES=0: sd 0x1122334455667788 @0x10, then ld @0x10 rd=5 → next cycle read_data_out=0x1122334455667788, RegWrite_out=1, rd_out=5, stall never 1.
- Sign/zero extension: after the store above, lb @0x10 → read_data_out=0xFFFFFFFFFFFFFF88; lbu → 0x88; lh @0x12 → 0x0000000000005566; lwu @0x14 → 0x11223344.
- WAIT_CYCLES=2: lw @0x20 held stable → stall=1 for 2 cycles, then 0; MEM/WB shows bubbles for 2 cycles, then the load data; total 3 cycles.
- Misaligned: lw @0x22 with RegWrite_in=1 → no stall, misaligned_out=1, RegWrite_out=0, memory unchanged.
- Branch: branch_in=1, zero_in=1, adder_in=0x400 → pc_src=1, branch_target=0x400 in the same cycle; zero_in=0 → pc_src=0.
- Reset mid-access: WAIT_CYCLES=3, sd in BUSY, reset pulsed low → all outputs 0, FSM IDLE, target bytes unchanged on a later ld.
- Wrap-around: MEM_BYTES=256, sd @0xFF8 → later ld @0xF8 returns the same data.

Source files
------------

// File: rtl/mem_stage.sv
// RV64 memory-access stage: little-endian data memory with wait states,
// branch resolution and the MEM/WB pipeline register.
module mem_stage #(
  parameter int MEM_BYTES   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] adder_in,
  input  logic        zero_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  output logic        pc_src,
  output logic [63:0] branch_target,
  output logic        stall,
  output logic [63:0] read_data_out,
  output logic [63:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        misaligned_out
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [7:0]     mem_q [MEM_BYTES];

  logic [63:0]    rdata_q;
  logic [63:0]    alu_q;
  logic [4:0]     rd_q;
  logic           m2r_q;
  logic           rw_q;
  logic           mis_q;

  logic [AW-1:0]  idx;
  logic [1:0]     sz;
  logic [3:0]     nbytes;
  logic           uns;
  logic           mem_op;
  logic           mis_a;
  logic           mis;
  logic           req;
  logic           done;
  logic           stall_w;
  logic [63:0]    raw;
  logic [63:0]    ext;
  logic [63:0]    rdata_d;

  assign idx    = alu_result_in[AW-1:0];
  assign sz     = funct3_in[1:0];
  assign nbytes = 4'd1 << sz;
  assign uns    = funct3_in[2] & (funct3_in != 3'b111);
  assign mem_op = MemRead_in | MemWrite_in;

  always_comb begin
    mis_a = 1'b0;
    unique case (sz)
      2'b00: mis_a = 1'b0;
      2'b01: mis_a = alu_result_in[0];
      2'b10: mis_a = |alu_result_in[1:0];
      2'b11: mis_a = |alu_result_in[2:0];
    endcase
  end

  assign mis = mem_op & mis_a;
  assign req = mem_op & ~mis;

  // Nothing stalls or commits while reset is held low.
  always_comb begin
    stall_w = 1'b0;
    done    = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (WAIT_CYCLES == 0) done = 1'b1;
            else                  stall_w = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == CW'(1)) done    = 1'b1;
          else                 stall_w = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      raw[8*k +: 8] = mem_q[idx + AW'(k)];
    end
  end

  always_comb begin
    ext = raw;
    unique case (sz)
      2'b00: ext = uns ? {56'd0, raw[7:0]}
                       : {{56{raw[7]}}, raw[7:0]};
      2'b01: ext = uns ? {48'd0, raw[15:0]}
                       : {{48{raw[15]}}, raw[15:0]};
      2'b10: ext = uns ? {32'd0, raw[31:0]}
                       : {{32{raw[31]}}, raw[31:0]};
      2'b11: ext = raw;
    endcase
  end

  assign rdata_d = (MemRead_in & ~MemWrite_in & ~mis) ? ext : 64'd0;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (done & MemWrite_in) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes) begin
          mem_q[idx + AW'(k)] <= write_data_in[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && (WAIT_CYCLES != 0)) begin
            state_q <= BUSY;
            cnt_q   <= CW'(WAIT_CYCLES);
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else if (stall_w) begin
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_result_in;
      rd_q    <= rd_in;
      m2r_q   <= MemtoReg_in;
      rw_q    <= RegWrite_in & ~mis;
      mis_q   <= mis;
    end
  end

  assign stall          = stall_w;
  assign pc_src         = branch_in & zero_in & ~stall_w;
  assign branch_target  = adder_in;
  assign read_data_out  = rdata_q;
  assign alu_result_out = alu_q;
  assign rd_out         = rd_q;
  assign MemtoReg_out   = m2r_q;
  assign RegWrite_out   = rw_q;
  assign misaligned_out = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a zero-wait and a three-wait instance
// share stimulus and are checked against a byte-array reference model.
module tb_mem_stage;

  localparam int W = 3;

  typedef struct packed {
    logic [63:0] rdat;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        mis;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] adder, alu, wdat;
  logic        zero, m2ri, rwi, bri, mri, mwi;
  logic [4:0]  rdi;
  logic [2:0]  f3i;

  logic        pc0, st0, m2r0, rw0, mis0;
  logic [63:0] bt0, rdd0, alu0;
  logic [4:0]  rdo0;
  logic        pc3, st3, m2r3, rw3, mis3;
  logic [63:0] bt3, rdd3, alu3;
  logic [4:0]  rdo3;

  always #5 clk = ~clk;

  mem_stage #(.MEM_BYTES(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .adder_in(adder), .zero_in(zero),
    .alu_result_in(alu), .write_data_in(wdat), .rd_in(rdi),
    .funct3_in(f3i), .MemtoReg_in(m2ri), .RegWrite_in(rwi),
    .branch_in(bri), .MemRead_in(mri), .MemWrite_in(mwi),
    .pc_src(pc0), .branch_target(bt0), .stall(st0),
    .read_data_out(rdd0), .alu_result_out(alu0), .rd_out(rdo0),
    .MemtoReg_out(m2r0), .RegWrite_out(rw0), .misaligned_out(mis0)
  );

  mem_stage #(.MEM_BYTES(256), .WAIT_CYCLES(W)) u3 (
    .clk(clk), .reset(reset), .adder_in(adder), .zero_in(zero),
    .alu_result_in(alu), .write_data_in(wdat), .rd_in(rdi),
    .funct3_in(f3i), .MemtoReg_in(m2ri), .RegWrite_in(rwi),
    .branch_in(bri), .MemRead_in(mri), .MemWrite_in(mwi),
    .pc_src(pc3), .branch_target(bt3), .stall(st3),
    .read_data_out(rdd3), .alu_result_out(alu3), .rd_out(rdo3),
    .MemtoReg_out(m2r3), .RegWrite_out(rw3), .misaligned_out(mis3)
  );

  wb_t        q0[$];
  wb_t        q3[$];
  logic [7:0] m0 [256];
  logic [7:0] m3 [256];
  int         pass_n = 0;
  int         tot_n  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cmp_wb(input string nm, input wb_t a, input wb_t e);
    chk({nm, ".read_data"}, a.rdat, e.rdat);
    chk({nm, ".alu_result"}, a.alu, e.alu);
    chk({nm, ".rd"}, 64'(a.rd), 64'(e.rd));
    chk({nm, ".MemtoReg"}, 64'(a.m2r), 64'(e.m2r));
    chk({nm, ".RegWrite"}, 64'(a.rw), 64'(e.rw));
    chk({nm, ".misaligned"}, 64'(a.mis), 64'(e.mis));
  endtask

  function automatic int bidx(input logic [63:0] a, input int k);
    return int'((a + 64'(k)) & 64'hFF);
  endfunction

  function automatic logic [63:0] ld_val(input int d, input logic [63:0] a,
                                         input logic [2:0] f3);
    int          n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (d == 0) v = v | (64'(m0[bidx(a, k)]) << (8 * k));
      else        v = v | (64'(m3[bidx(a, k)]) << (8 * k));
    end
    if (!(f3[2] && f3 != 3'b111) && n < 8 && v[8*n-1])
      v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic st_mem(input int d, input logic [63:0] a,
                        input logic [2:0] f3, input logic [63:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) begin
      if (d == 0) m0[bidx(a, k)] = 8'(wd >> (8 * k));
      else        m3[bidx(a, k)] = 8'(wd >> (8 * k));
    end
  endtask

  // One instruction, held for as long as the slow instance needs it.
  task automatic op(input logic rdE, input logic wrE, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] wd,
                    input logic [4:0] rd, input logic m2r, input logic rw,
                    input logic br, input logic z, input logic [63:0] tgt);
    int   n, hold;
    logic mis, req, bub;
    wb_t  e0, e3;
    n    = 1 << f3[1:0];
    mis  = (rdE | wrE) && ((int'(a[2:0]) % n) != 0);
    req  = (rdE | wrE) && !mis;
    e0   = '{rdat: (rdE && !wrE && !mis) ? ld_val(0, a, f3) : 64'd0,
             alu: a, rd: rd, m2r: m2r, rw: rw && !mis, mis: mis};
    e3   = e0;
    e3.rdat = (rdE && !wrE && !mis) ? ld_val(3, a, f3) : 64'd0;
    mri = rdE; mwi = wrE; f3i = f3; alu = a; wdat = wd; rdi = rd;
    m2ri = m2r; rwi = rw; bri = br; zero = z; adder = tgt;
    hold = req ? W + 1 : 1;
    for (int c = 0; c < hold; c++) begin
      bub = req && (c < W);
      q0.push_back(e0);
      q3.push_back(bub ? wb_t'(0) : e3);
      #1;
      chk("stall0", 64'(st0), 64'(0));
      chk("stall3", 64'(st3), 64'(bub));
      chk("pc_src0", 64'(pc0), 64'(br & z));
      chk("pc_src3", 64'(pc3), 64'(br & z & !bub));
      if (c == 0) chk("branch_target", bt0, tgt);
      @(negedge clk);
    end
    if (req && wrE) begin
      st_mem(0, a, f3, wd);
      st_mem(3, a, f3, wd);
    end
  endtask

  task automatic nop();
    op(0, 0, 3'd0, 64'(0), 64'd0, 5'd0, 0, 0, 0, 0, 64'd0);
  endtask

  initial begin : monitor
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp_wb("u0", {rdd0, alu0, rdo0, m2r0, rw0, mis0}, e);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        cmp_wb("u3", {rdd3, alu3, rdo3, m2r3, rw3, mis3}, e);
      end
    end
  end

  initial begin : stim
    logic [63:0] a, d;
    logic [2:0]  f3;
    int          kind, n;
    reset = 1'b0;
    adder = '0; alu = '0; wdat = '0; zero = 0; m2ri = 0; rwi = 0;
    bri = 0; mri = 0; mwi = 0; rdi = '0; f3i = '0;
    repeat (2) @(negedge clk);
    chk("rst.rdata0", rdd0, 64'd0);
    chk("rst.rw0", 64'(rw0), 64'd0);
    chk("rst.rd3", 64'(rdo3), 64'd0);
    chk("rst.alu3", alu3, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++)
      op(0, 1, 3'd3, 64'(i * 8), {$urandom, $urandom}, 5'd0, 0, 0, 0, 0, 64'd0);

    op(0, 1, 3'd3, 64'h10, 64'h1122334455667788, 5'd0, 0, 0, 0, 0, 64'd0);
    op(1, 0, 3'd3, 64'h10, 64'd0, 5'd5, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd0, 64'h10, 64'd0, 5'd6, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd4, 64'h10, 64'd0, 5'd7, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd1, 64'h12, 64'd0, 5'd8, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd6, 64'h14, 64'd0, 5'd9, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd2, 64'h20, 64'd0, 5'd10, 1, 1, 0, 0, 64'd0);
    op(1, 0, 3'd2, 64'h22, 64'd0, 5'd11, 1, 1, 0, 0, 64'd0);
    op(0, 1, 3'd3, 64'h13, 64'hFFFF, 5'd0, 0, 0, 0, 0, 64'd0);
    op(1, 0, 3'd3, 64'h10, 64'd0, 5'd12, 1, 1, 0, 0, 64'd0);
    op(0, 0, 3'd0, 64'h5, 64'd0, 5'd3, 0, 1, 1, 1, 64'h400);
    op(0, 0, 3'd0, 64'h5, 64'd0, 5'd3, 0, 1, 1, 0, 64'h400);
    op(1, 1, 3'd2, 64'h28, 64'hA5A5_5A5A, 5'd4, 1, 1, 1, 1, 64'h80);
    op(1, 0, 3'd2, 64'h28, 64'd0, 5'd4, 1, 1, 0, 0, 64'd0);
    op(0, 1, 3'd3, 64'hFF8, 64'hCAFE_0123_4567_89AB, 5'd0, 0, 0, 0, 0, 64'd0);
    op(1, 0, 3'd3, 64'hF8, 64'd0, 5'd13, 1, 1, 0, 0, 64'd0);
    op(0, 1, 3'd3, 64'hFC, 64'h0102_0304_0506_0708, 5'd0, 0, 0, 0, 0, 64'd0);
    op(1, 0, 3'd2, 64'h0, 64'd0, 5'd14, 1, 1, 0, 0, 64'd0);

    // Reset lands while the slow instance is mid-store.
    a = 64'h30;
    d = 64'hDEAD_BEEF_CAFE_F00D;
    mri = 0; mwi = 1; f3i = 3'd3; alu = a; wdat = d; rdi = 5'd0;
    m2ri = 0; rwi = 0; bri = 0; zero = 0; adder = '0;
    q0.push_back('{rdat: 64'd0, alu: a, rd: 5'd0, m2r: 0, rw: 0, mis: 0});
    q3.push_back('0);
    #1;
    chk("busy.stall3", 64'(st3), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid.stall3", 64'(st3), 64'd0);
    chk("rstmid.stall0", 64'(st0), 64'd0);
    chk("rstmid.rdata0", rdd0, 64'd0);
    chk("rstmid.alu0", alu0, 64'd0);
    chk("rstmid.alu3", alu3, 64'd0);
    chk("rstmid.rw3", 64'(rw3), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("rstmid.hold.alu3", alu3, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    st_mem(0, a, 3'd3, d);
    op(1, 0, 3'd3, a, 64'd0, 5'd15, 1, 1, 0, 0, 64'd0);
    nop();

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      f3   = 3'($urandom_range(0, 7));
      n    = 1 << f3[1:0];
      a    = {$urandom, $urandom};
      a[7:0] = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) a[2:0] = a[2:0] & ~3'(n - 1);
      op(kind inside {[3:5]} || kind == 9, kind inside {[6:9]}, f3, a,
         {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom), {$urandom, $urandom});
    end

    nop();
    @(posedge clk);
    #2;
    chk("q0.drained", 64'(q0.size()), 64'd0);
    chk("q3.drained", 64'(q3.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
